// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The arbiter takes the slave side; whoever drives req/done takes the master side.
interface rr_arbiter8_if #(
    parameter int N = 8
);
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         timeout;

    modport master (output req, output done, input gnt, input gnt_valid, input timeout);
    modport slave  (input req, input done, output gnt, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with a registered one-hot grant held for a whole transaction.
// A transaction ends on done, on the owner dropping its request, or on hold-time expiry.
module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);
    localparam int PTR_W  = $clog2(N);
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic                gnt_valid_q;
    logic                timeout_q, timeout_d;

    logic [PTR_W-1:0]    search_start;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic                expired;
    logic                owner_req;
    logic                release_now;

    // Scanning offsets from high to low lets the closest requester overwrite farther ones.
    function automatic logic [PTR_W:0] find_winner(input logic [N-1:0] r,
                                                   input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] idx;
        find_winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = start + PTR_W'(i);
            if (r[idx]) find_winner = {1'b1, idx};
        end
    endfunction

    // On release the search starts just past the owner, which is exactly the new ptr.
    assign search_start = (state_q == OWNED) ? owner_q + PTR_W'(1) : ptr_q;
    assign {win_found, win_idx} = find_winner(bus.req, search_start);

    assign expired     = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);
    assign owner_req   = bus.req[owner_q];
    assign release_now = bus.done || !owner_req || expired;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = OWNED;
                    owner_d = win_idx;
                    gnt_d   = N'(1) << win_idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            OWNED: begin
                if (!release_now) begin
                    if (MAX_HOLD != 0 && hold_q != HOLD_LIMIT) hold_d = hold_q + HOLD_W'(1);
                end else begin
                    ptr_d     = search_start;
                    timeout_d = expired && !bus.done && owner_req;
                    if (win_found) begin
                        owner_d = win_idx;
                        gnt_d   = N'(1) << win_idx;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= |gnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (hold limit 4): directed vector table, hand sequences, then random
// traffic compared against a transaction-level model of the arbitration rules.
module tb_rr_arbiter8;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] exp_gnt;
        logic       exp_to;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Model state: owner index or -1, rotating start index, cycles the owner has held.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    rr_arbiter8_if #(.N(8)) bus ();

    rr_arbiter8 #(.N(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_search(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++)
            if (r[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int  w;
        bit  exp_hold;
        bit  rel;
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            w = m_search(bus.req, m_ptr);
            if (w >= 0) begin m_owner = w; m_hold = 1; end
        end else begin
            exp_hold = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
            rel      = bus.done || !bus.req[m_owner] || exp_hold;
            if (!rel) begin
                if (m_hold < MAX_HOLD) m_hold++;
            end else begin
                m_to  = exp_hold && !bus.done && bus.req[m_owner];
                m_ptr = (m_owner + 1) % 8;
                w     = m_search(bus.req, m_ptr);
                if (w >= 0) begin m_owner = w; m_hold = 1; end
                else        begin m_owner = -1; m_hold = 0; end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare outputs against the model.
    task automatic cycle(input logic r, input logic [7:0] q, input logic d);
        logic [7:0] mg;
        rst = r; bus.req = q; bus.done = d;
        model_step();
        @(posedge clk);
        #1;
        mg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        check("model_gnt",     32'(bus.gnt),       32'(mg));
        check("model_timeout", 32'(bus.timeout),   32'(m_to));
        check("gnt_valid",     32'(bus.gnt_valid), 32'(|bus.gnt));
        check("onehot",        32'($countones(bus.gnt) <= 1), 32'(1));
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        cycle(v.rst, v.req, v.done);
        check({name, "_gnt"}, 32'(bus.gnt),     32'(v.exp_gnt));
        check({name, "_to"},  32'(bus.timeout), 32'(v.exp_to));
    endtask

    vec_t vecs[$];

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;

        // Idle after reset, pass-through 81, full walk with wrap, reset mid-grant.
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h81, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 8'h81, 1'b1, 8'h80, 1'b0});
        vecs.push_back('{1'b0, 8'h81, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'hFF, 1'b0, 8'h01, 1'b0});
        for (int i = 1; i <= 8; i++)
            vecs.push_back('{1'b0, 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b0});
        vecs.push_back('{1'b0, 8'h20, 1'b1, 8'h20, 1'b0});
        vecs.push_back('{1'b1, 8'h20, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h21, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0});

        foreach (vecs[i]) apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Sole requester hits the hold limit: regranted with a timeout pulse.
        apply_vec("exp_rst", '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < 4; i++) apply_vec("solo_hold", '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0});
        apply_vec("solo_expire", '{1'b0, 8'h04, 1'b0, 8'h04, 1'b1});
        apply_vec("solo_after",  '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0});

        // Two requesters: expiry hands the grant to the next one.
        apply_vec("pair_rst", '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < 4; i++) apply_vec("pair_hold", '{1'b0, 8'h0C, 1'b0, 8'h04, 1'b0});
        apply_vec("pair_expire", '{1'b0, 8'h0C, 1'b0, 8'h08, 1'b1});
        apply_vec("pair_after",  '{1'b0, 8'h0C, 1'b0, 8'h08, 1'b0});

        // Owner drops its request: grant clears without timeout.
        apply_vec("drop_rst",   '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        apply_vec("drop_grant", '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0});
        apply_vec("drop_rel",   '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0});

        // done coincides with expiry: no timeout pulse.
        apply_vec("both_rst", '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < 4; i++) apply_vec("both_hold", '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0});
        apply_vec("both_rel", '{1'b0, 8'h04, 1'b1, 8'h04, 1'b0});

        // Randomized traffic: sticky requests, occasional done and reset.
        begin
            logic [7:0] q;
            q = 8'h00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(3) == 0) q = 8'($urandom);
                if ($urandom_range(15) == 0) q = 8'h00;
                cycle($urandom_range(99) == 0, q, $urandom_range(3) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
